mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory-access stage (loads and stores).
- Sits between the pipeline stages and the memory, in place of the separate program and data memories.
- Serialises requests and presents stall indications to the pipeline.
- Discards fetch responses that a control-flow flush has made stale.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; after this many, fetch wins the next arbitration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline redirect; the current or pending fetch is stale.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  fetch complete; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  data access complete.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; may assert in the first cycle mem_req is high.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- if_stall  out  1  if_req & ~if_ack.
- d_stall  out  1  d_req & ~d_ack.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; starve_cnt = 0.
  - mem_req, mem_we = 0; mem_wstrb, mem_addr, mem_wdata = 0.
  - All acks = 0; rdata outputs = 0.
  - A transaction in flight is abandoned; a mem_ack arriving after reset is ignored in IDLE.
- States: IDLE, BUSY_IF, BUSY_D, DRAIN.
- IDLE arbitration, registered, one cycle:
  - d_req only -> BUSY_D.
  - if_req & ~flush only -> BUSY_IF.
  - Both requesting: fetch wins if starve_cnt == STARVE_MAX, otherwise data wins.
  - On a data grant with if_req high: starve_cnt += 1, saturating at STARVE_MAX.
  - On a fetch grant: starve_cnt = 0.
  - Grant with flush high: fetch is never granted; data may be.
  - On grant, latch address, we, wstrb and wdata into the mem_* registers and set mem_req = 1 in the next cycle.
  - Fetch grants force mem_we = 0 and mem_wstrb = 0.
- BUSY_D:
  - d_ack = mem_ack (combinational); d_rdata = mem_rdata pass-through.
  - On mem_ack: mem_req = 0, return to IDLE.
- BUSY_IF:
  - if_ack = mem_ack & ~flush; if_rdata = mem_rdata.
  - flush without mem_ack -> DRAIN.
  - flush coincident with mem_ack -> IDLE with if_ack suppressed.
- DRAIN:
  - mem_req stays high; the memory cannot abort.
  - if_ack is never asserted.
  - On mem_ack -> IDLE; the response is dropped.
- Requester contract: the requester deasserts req in the cycle after its ack. Because acks are same-cycle, IDLE never re-grants a served request.
- Throughput: minimum 2 cycles per access (grant cycle + ack cycle); there is no bubble after IDLE.
- Request inputs are sampled only in IDLE. Changes to if_addr/d_addr while busy are ignored until the next grant.
- Store and load ordering follows grant order; at most one outstanding memory transaction.
- A flush while the arbiter is in BUSY_D or IDLE does not affect data transactions.

Decomposition:
- Shared package (kasumi_pkg):
  - State encoding localparams ST_IDLE, ST_BUSY_IF, ST_BUSY_D, ST_DRAIN.
  - Default ADDR_W/DATA_W.
- Sub-module: arb_starve_ctr, the saturating starvation counter with increment/clear/at_max outputs. Everything else stays flat.

Test Plan:
- Reset then if_req, if_addr=0x100; memory acks 1 cycle after mem_req with 0x00000013 -> mem_addr=0x100, mem_we=0, if_ack pulse with if_rdata=0x00000013; if_stall high until the ack.
- if_req and d_req (store 0xDEADBEEF to 0x2000, wstrb=0xF) raised together -> data granted first (mem_we=1, mem_addr=0x2000), then the fetch; exactly one d_ack and one if_ack.
- Fetch and data held continuously with d_req re-raised each time (STARVE_MAX=4) -> 4 data grants, then 1 fetch grant, starve_cnt back to 0.
- Fetch in BUSY_IF, flush pulsed 1 cycle, mem_ack 3 cycles later -> DRAIN entered, no if_ack, mem_req held until mem_ack, IDLE afterwards; a new if_addr=0x200 is served next.
- rst asserted mid-BUSY_D -> all outputs 0 immediately (asynchronous); a stray mem_ack afterwards produces no d_ack.
- mem_ack high in the first mem_req cycle -> ack same cycle, next grant the following cycle (2-cycle throughput).

Source files
------------

// File: rtl/kasumi_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding and
// default bus widths.
package kasumi_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_BUSY_IF = ST_BUSY_IF,
        S_BUSY_D  = ST_BUSY_D,
        S_DRAIN   = ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch waits;
// at_max tells the arbiter that the fetch must win the next arbitration.
module arb_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] cnt_r;

    // Counter register: clear has priority, increment saturates at MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && !at_max) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// load/store stage, with stall generation and stale-fetch dropping on flush.
module mem_arbiter import kasumi_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                if_stall,
    output logic                d_stall
);

    arb_state_e          state_r;
    arb_state_e          next_state_s;
    logic                fetch_ok_s;
    logic                grant_if_s;
    logic                grant_d_s;
    logic                starve_inc_s;
    logic                starve_clr_s;
    logic                starve_max_s;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [DATA_W/8-1:0] mem_wstrb_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc_s),
        .clr    (starve_clr_s),
        .at_max (starve_max_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration and next-state; a flushed fetch is never granted
    always_comb begin
        next_state_s = state_r;
        grant_if_s   = 1'b0;
        grant_d_s    = 1'b0;
        starve_inc_s = 1'b0;
        starve_clr_s = 1'b0;
        fetch_ok_s   = if_req & ~flush;
        case (state_r)
            S_IDLE: begin
                if (fetch_ok_s && (!d_req || starve_max_s)) begin
                    grant_if_s   = 1'b1;
                    starve_clr_s = 1'b1;
                    next_state_s = S_BUSY_IF;
                end else if (d_req) begin
                    grant_d_s    = 1'b1;
                    starve_inc_s = if_req;
                    next_state_s = S_BUSY_D;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_BUSY_IF: begin
                if (mem_ack) begin
                    next_state_s = S_IDLE;
                end else if (flush) begin
                    next_state_s = S_DRAIN;
                end else begin
                    next_state_s = S_BUSY_IF;
                end
            end
            S_BUSY_D: begin
                if (mem_ack) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_BUSY_D;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Memory-side request registers, loaded on grant and released on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wstrb_r <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (grant_if_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_wstrb_r <= '0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= '0;
        end else if (grant_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_wstrb_r <= d_wstrb;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
        end else if (mem_ack && (state_r != S_IDLE)) begin
            mem_req_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_r;
        end
    end

    // Requester-side completion; acks follow mem_ack within the same cycle
    always_comb begin
        if_ack   = 1'b0;
        if_rdata = '0;
        d_ack    = 1'b0;
        d_rdata  = '0;
        case (state_r)
            S_BUSY_IF: begin
                if_ack   = mem_ack & ~flush;
                if_rdata = mem_rdata;
            end
            S_BUSY_D: begin
                d_ack    = mem_ack;
                d_rdata  = mem_rdata;
            end
            default: begin
                if_ack   = 1'b0;
                d_ack    = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_wstrb = mem_wstrb_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model with reference memory.
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        d_stall;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        return 32'h0000_1000 + {26'd0, w, 2'b00};
    endfunction

    // model state: kind 0 = idle, 1 = fetch outstanding, 2 = data outstanding
    int          m_kind;
    int          starve;
    logic        m_stale;
    logic        m_fresh;
    logic [31:0] g_addr;
    logic        g_we;
    logic [3:0]  g_strb;
    logic [31:0] g_wdata;
    logic        got_if;
    logic        got_d;
    logic        e_if;
    logic        e_d;
    logic        fok;
    logic        resp_busy;
    int          resp_wait;
    logic        exp_f;

    initial begin
        rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #2;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check1("rst_if_ack", if_ack, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);
        tick(); tick(); rst = 1'b0;

        // single fetch, memory answers one cycle after mem_req
        tick(); if_req = 1'b1; if_addr = 32'h0000_0100;
        sample(); check1("t1_idle_req", mem_req, 1'b0); check1("t1_stall0", if_stall, 1'b1);
        tick();
        sample(); check1("t1_req", mem_req, 1'b1); check32("t1_addr", mem_addr, 32'h100);
        check1("t1_we", mem_we, 1'b0); check1("t1_noack", if_ack, 1'b0);
        check1("t1_stall1", if_stall, 1'b1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        sample(); check1("t1_ack", if_ack, 1'b1); check32("t1_rdata", if_rdata, 32'h13);
        check1("t1_stall2", if_stall, 1'b0);
        tick(); mem_ack = 1'b0; mem_rdata = 32'h0; if_req = 1'b0;
        sample(); check1("t1_release", mem_req, 1'b0); check1("t1_ack_once", if_ack, 1'b0);

        // simultaneous fetch and store: store first
        tick(); if_req = 1'b1; if_addr = 32'h0000_0104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        tick(); mem_ack = 1'b1;
        sample(); check1("t2_we", mem_we, 1'b1); check32("t2_addr", mem_addr, 32'h2000);
        check32("t2_wdata", mem_wdata, 32'hDEAD_BEEF); check32("t2_strb", {28'd0, mem_wstrb}, 32'hF);
        check1("t2_dack", d_ack, 1'b1); check1("t2_ifack0", if_ack, 1'b0);
        check1("t2_istall", if_stall, 1'b1);
        tick(); mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        sample(); check1("t2_idle", mem_req, 1'b0); check1("t2_dack_once", d_ack, 1'b0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
        sample(); check32("t2_faddr", mem_addr, 32'h104); check1("t2_fwe", mem_we, 1'b0);
        check32("t2_fstrb", {28'd0, mem_wstrb}, 32'h0); check1("t2_ifack", if_ack, 1'b1);
        check32("t2_ifrdata", if_rdata, 32'h93); check1("t2_dack0", d_ack, 1'b0);
        tick(); mem_ack = 1'b0; if_req = 1'b0;

        // starvation bound: four data grants, then the waiting fetch
        tick(); if_req = 1'b1; if_addr = 32'h0000_0300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        for (int k = 0; k < 10; k++) begin
            tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_A000 + 32'(k);
            sample();
            exp_f = ((k % 5) == 4);
            check32("t3_addr", mem_addr, exp_f ? if_addr : 32'h40);
            check1("t3_ifack", if_ack, exp_f);
            check1("t3_dack", d_ack, !exp_f);
            if (!exp_f) check32("t3_drdata", d_rdata, 32'h0000_A000 + 32'(k));
            tick(); mem_ack = 1'b0;
            if (exp_f) if_addr = if_addr + 32'h4;
            if (k == 9) begin if_req = 1'b0; d_req = 1'b0; end
            sample(); check1("t3_gap", mem_req, 1'b0);
        end

        // flush during fetch: drain, drop response, serve redirected fetch
        tick(); if_req = 1'b1; if_addr = 32'h0000_0180;
        tick(); flush = 1'b1;
        sample(); check1("t4_req", mem_req, 1'b1); check1("t4_noack", if_ack, 1'b0);
        tick(); flush = 1'b0; if_addr = 32'h0000_0200;
        sample(); check1("t4_drain1", mem_req, 1'b1); check1("t4_noack1", if_ack, 1'b0);
        check1("t4_stall", if_stall, 1'b1);
        tick();
        sample(); check1("t4_drain2", mem_req, 1'b1); check32("t4_oldaddr", mem_addr, 32'h180);
        tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_0180;
        sample(); check1("t4_dropped", if_ack, 1'b0); check1("t4_held", mem_req, 1'b1);
        tick(); mem_ack = 1'b0;
        sample(); check1("t4_idle", mem_req, 1'b0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
        sample(); check32("t4_newaddr", mem_addr, 32'h200); check1("t4_ack", if_ack, 1'b1);
        check32("t4_rdata", if_rdata, 32'h2222);
        tick(); mem_ack = 1'b0; if_req = 1'b0;

        // asynchronous reset in the middle of a store
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
        tick();
        sample(); check1("t5_busy", mem_req, 1'b1); check1("t5_we", mem_we, 1'b1);
        #1; rst = 1'b1; #1;
        check1("t5_req0", mem_req, 1'b0); check1("t5_we0", mem_we, 1'b0);
        check32("t5_addr0", mem_addr, 32'h0); check32("t5_wdata0", mem_wdata, 32'h0);
        check32("t5_strb0", {28'd0, mem_wstrb}, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); rst = 1'b0; mem_ack = 1'b1;
        sample(); check1("t5_stray_dack", d_ack, 1'b0); check1("t5_stray_ifack", if_ack, 1'b0);
        tick(); mem_ack = 1'b0;
        sample(); check1("t5_idle", mem_req, 1'b0);

        // randomized traffic against the transaction model
        m_kind = 0; starve = 0; m_stale = 1'b0; m_fresh = 1'b0;
        got_if = 1'b0; got_d = 1'b0; resp_busy = 1'b0; resp_wait = 0;
        g_addr = 32'h0; g_we = 1'b0; g_strb = 4'h0; g_wdata = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (got_if) if_req = 1'b0;
            if (got_d) d_req = 1'b0;
            flush = ($urandom_range(0, 9) == 0);
            if (flush && if_req) if_addr = rand_addr();
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!resp_busy) begin resp_busy = 1'b1; resp_wait = $urandom_range(0, 3); end
                if (resp_wait == 0) begin
                    mem_ack = 1'b1; resp_busy = 1'b0;
                    if (mem_we) begin
                        phys_mem[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_wstrb);
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = phys_rd(mem_addr);
                    end
                end else begin
                    resp_wait--;
                end
            end

            sample();
            check1("r_mem_req", mem_req, m_kind != 0);
            if (m_fresh) begin
                check32("r_addr", mem_addr, g_addr);
                check1("r_we", mem_we, g_we);
                check32("r_strb", {28'd0, mem_wstrb}, {28'd0, g_strb});
                if (g_we) check32("r_wdata", mem_wdata, g_wdata);
                m_fresh = 1'b0;
            end
            e_if = mem_ack && (m_kind == 1) && !m_stale && !flush;
            e_d  = mem_ack && (m_kind == 2);
            check1("r_if_ack", if_ack, e_if);
            check1("r_d_ack", d_ack, e_d);
            check1("r_if_stall", if_stall, if_req && !e_if);
            check1("r_d_stall", d_stall, d_req && !e_d);
            if (e_if) check32("r_if_rdata", if_rdata, ref_rd(g_addr));
            if (e_d) begin
                if (g_we) ref_mem[g_addr] = merge(ref_rd(g_addr), g_wdata, g_strb);
                else check32("r_d_rdata", d_rdata, ref_rd(g_addr));
            end
            got_if = e_if; got_d = e_d;
            if (m_kind == 1 && flush) m_stale = 1'b1;
            if (m_kind != 0) begin
                if (mem_ack) m_kind = 0;
            end else begin
                fok = if_req && !flush;
                if (fok && (!d_req || starve >= SMAX)) begin
                    m_kind = 1; starve = 0;
                    g_addr = if_addr; g_we = 1'b0; g_strb = 4'h0; g_wdata = 32'h0;
                end else if (d_req) begin
                    m_kind = 2;
                    if (if_req && starve < SMAX) starve++;
                    g_addr = d_addr; g_we = d_we; g_strb = d_wstrb; g_wdata = d_wdata;
                end
                if (m_kind != 0) begin m_fresh = 1'b1; m_stale = 1'b0; end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
